clk_div_ctrl: RTL

Sequencing controller and two-port arbiter for the integer clock divider. Two requesters (A and B) use a four-phase REQ/ACK handshake to ask for a new division ratio. The controller grants one at a time and quiesces the divider by dropping CLK_EN. It then loads the new DIV_RATIO, re-enables the divider and holds ACK until one full divided period has elapsed. It sits in the I_REF_CLK domain and drives the divider's DIV_RATIO and CLK_EN inputs directly.

---
 rtl/clk_div_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: sequencing controller and round-robin arbiter for the integer
// clock divider. Two requesters ask for a new division ratio over a four-phase
// REQ/ACK handshake; the controller stops the divider, loads the new ratio,
// restarts it and acknowledges once one full divided period has elapsed.
module clk_div_ctrl #(
  parameter logic [7:0]  RESET_RATIO   = 8'd2,
  parameter int unsigned SETTLE_CYCLES = 4     // legal range 1..255
) (
  input  logic       I_REF_CLK,
  input  logic       RST_EN,
  input  logic       REQ_A,
  input  logic [7:0] RATIO_A,
  input  logic       REQ_B,
  input  logic [7:0] RATIO_B,
  output logic       ACK_A,
  output logic       ACK_B,
  output logic       BUSY,
  output logic [7:0] DIV_RATIO,
  output logic       CLK_EN
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_IDLE,
    S_STOP,
    S_LOAD,
    S_START,
    S_ACK
  } state_t;

  // Last counter value of the settle window (counter runs 0..SETTLE_CYCLES-1).
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  // Side encoding for owner and pointer: 0 = requester A, 1 = requester B.
  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_owner;
  logic [7:0] r_ratio;
  logic       r_ptr;
  logic [7:0] r_cnt;
  logic [7:0] r_div_ratio;
  logic       r_clk_en;
  logic       r_busy;
  logic       r_ack_a;
  logic       r_ack_b;

  logic       w_owner_nxt;
  logic [7:0] w_ratio_nxt;
  logic       w_ptr_nxt;
  logic [7:0] w_cnt_nxt;
  logic [7:0] w_div_ratio_nxt;
  logic       w_clk_en_nxt;
  logic       w_busy_nxt;
  logic       w_ack_a_nxt;
  logic       w_ack_b_nxt;

  logic       w_elig_a;
  logic       w_elig_b;
  logic       w_grant_any;
  logic       w_grant_b;
  logic [7:0] w_req_ratio;
  logic       w_fast;
  logic       w_owner_req;
  logic       w_owner_ack;
  logic [7:0] w_start_last;
  logic       w_stop_done;
  logic       w_start_done;

  // Arbitration and sequencing terms shared by next-state and output logic.
  always_comb begin
    w_elig_a     = REQ_A & ~r_ack_a;
    w_elig_b     = REQ_B & ~r_ack_b;
    w_grant_any  = w_elig_a | w_elig_b;
    // B wins when it is the only eligible side or when the pointer names B.
    w_grant_b    = w_elig_b & (~w_elig_a | r_ptr);
    w_req_ratio  = w_grant_b ? RATIO_B : RATIO_A;
    // Same ratio on a running divider needs no stop/start sequence.
    w_fast       = (w_req_ratio == r_div_ratio) & r_clk_en;
    w_owner_req  = r_owner ? REQ_B : REQ_A;
    w_owner_ack  = r_owner ? r_ack_b : r_ack_a;
    // Ratios 0 and 1 are divider bypass: one reference cycle is a full period.
    w_start_last = (r_ratio >= 8'd2) ? (r_ratio - 8'd1) : 8'd0;
    w_stop_done  = (r_cnt == SETTLE_LAST);
    w_start_done = (r_cnt == w_start_last);
  end

  // State register.
  always_ff @(posedge I_REF_CLK or negedge RST_EN) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!RST_EN) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch
    // is inferred when a branch leaves the state unchanged.
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:  w_state_nxt = S_IDLE;
      S_IDLE:  if (w_grant_any) w_state_nxt = w_fast ? S_ACK : S_STOP;
      S_STOP:  if (w_stop_done) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_START;
      S_START: if (w_start_done) w_state_nxt = S_ACK;
      S_ACK:   if (w_owner_ack && !w_owner_req) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  // Next values of the registered datapath and outputs for each state.
  always_comb begin
    w_owner_nxt     = r_owner;
    w_ratio_nxt     = r_ratio;
    w_ptr_nxt       = r_ptr;
    w_cnt_nxt       = r_cnt;
    w_div_ratio_nxt = r_div_ratio;
    w_clk_en_nxt    = r_clk_en;
    w_busy_nxt      = r_busy;
    w_ack_a_nxt     = r_ack_a;
    w_ack_b_nxt     = r_ack_b;
    case (r_state)
      S_BOOT: begin
        w_clk_en_nxt = 1'b1;
        w_busy_nxt   = 1'b0;
      end
      S_IDLE: begin
        if (w_grant_any) begin
          w_owner_nxt = w_grant_b;
          w_ratio_nxt = w_req_ratio;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = 8'd0;
          if (!w_fast) w_clk_en_nxt = 1'b0;
        end
      end
      S_STOP: begin
        if (!w_stop_done) w_cnt_nxt = r_cnt + 8'd1;
      end
      S_LOAD: begin
        // The divider is stopped here, so the ratio never changes while enabled.
        w_div_ratio_nxt = r_ratio;
        w_clk_en_nxt    = 1'b1;
        w_cnt_nxt       = 8'd0;
      end
      S_START: begin
        if (w_start_done) begin
          if (r_owner) w_ack_b_nxt = 1'b1;
          else         w_ack_a_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_ACK: begin
        if (!w_owner_ack) begin
          // Fast-path entry: ACK rises one edge after the grant.
          if (r_owner) w_ack_b_nxt = 1'b1;
          else         w_ack_a_nxt = 1'b1;
        end else if (!w_owner_req) begin
          if (r_owner) w_ack_b_nxt = 1'b0;
          else         w_ack_a_nxt = 1'b0;
          w_busy_nxt = 1'b0;
          w_ptr_nxt  = ~r_owner;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers; reset returns the divider to its boot ratio.
  always_ff @(posedge I_REF_CLK or negedge RST_EN) begin
    if (!RST_EN) begin
      r_owner     <= 1'b0;
      r_ratio     <= RESET_RATIO;
      r_ptr       <= 1'b0;
      r_cnt       <= 8'd0;
      r_div_ratio <= RESET_RATIO;
      r_clk_en    <= 1'b0;
      r_busy      <= 1'b1;
      r_ack_a     <= 1'b0;
      r_ack_b     <= 1'b0;
    end else begin
      r_owner     <= w_owner_nxt;
      r_ratio     <= w_ratio_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_div_ratio <= w_div_ratio_nxt;
      r_clk_en    <= w_clk_en_nxt;
      r_busy      <= w_busy_nxt;
      r_ack_a     <= w_ack_a_nxt;
      r_ack_b     <= w_ack_b_nxt;
    end
  end

  assign ACK_A     = r_ack_a;
  assign ACK_B     = r_ack_b;
  assign BUSY      = r_busy;
  assign DIV_RATIO = r_div_ratio;
  assign CLK_EN    = r_clk_en;

endmodule
